// File: rtl/mult_div_pkg.sv
// Shared definitions for the multi-cycle MULT/DIV sequencer: op codes, FSM states
// and the fixed constants used by the datapath.
package mult_div_pkg;

    localparam int ITER = 32;
    localparam logic [ITER-1:0] DBZ_LO = '1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step or a
// restoring-divide step on the {hi_acc, lo_reg} pair.
module mult_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] hi_acc,
    input  logic [DATA_W-1:0] lo_reg,
    input  logic [DATA_W-1:0] operand,
    input  logic              is_div,
    output logic [DATA_W-1:0] next_hi,
    output logic [DATA_W-1:0] next_lo
);

    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] rem_shift;
    logic [DATA_W:0] trial;

    // Remainder stays below the divisor, so a 33-bit trial subtract has a reliable sign bit.
    always_comb begin
        next_hi   = hi_acc;
        next_lo   = lo_reg;
        add_sum   = {1'b0, hi_acc} + (lo_reg[0] ? {1'b0, operand} : '0);
        rem_shift = {hi_acc, lo_reg[DATA_W-1]};
        trial     = rem_shift - {1'b0, operand};
        if (is_div) begin
            if (!trial[DATA_W]) begin
                next_hi = trial[DATA_W-1:0];
                next_lo = {lo_reg[DATA_W-2:0], 1'b1};
            end else begin
                next_hi = rem_shift[DATA_W-1:0];
                next_lo = {lo_reg[DATA_W-2:0], 1'b0};
            end
        end else begin
            next_hi = add_sum[DATA_W:1];
            next_lo = {add_sum[0], lo_reg[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one iteration per clock with a
// fixed 34-cycle latency from the accepting edge to the result.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int DATA_W = ITER,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    input  logic              i_wr_hi,
    input  logic              i_wr_lo,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_by_zero,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   operand_q;
    logic [DATA_W-1:0]   hi_acc;
    logic [DATA_W-1:0]   lo_acc;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                res_neg;
    logic                rem_neg;
    logic                dbz_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_out_q;

    logic                is_signed_op;
    logic                is_div_op;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [2*DATA_W-1:0] neg_prod;
    logic [DATA_W-1:0]   step_hi;
    logic [DATA_W-1:0]   step_lo;

    assign is_signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign is_div_op    = (op_q == OP_DIV)  || (op_q == OP_DIVU);
    assign a_neg        = is_signed_op & a_q[DATA_W-1];
    assign b_neg        = is_signed_op & b_q[DATA_W-1];
    assign abs_a        = a_neg ? -a_q : a_q;
    assign abs_b        = b_neg ? -b_q : b_q;
    assign neg_prod     = -{hi_acc, lo_acc};

    mult_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .hi_acc  (hi_acc),
        .lo_reg  (lo_acc),
        .operand (operand_q),
        .is_div  (is_div_op),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            operand_q <= '0;
            hi_acc    <= '0;
            lo_acc    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_wr_hi) hi_q <= i_wr_data;
                    if (i_wr_lo) lo_q <= i_wr_data;
                    if (i_start) begin
                        op_q   <= op_e'(i_op);
                        a_q    <= i_A;
                        b_q    <= i_B;
                        busy_q <= 1'b1;
                        state  <= PREP;
                    end else begin
                        state  <= IDLE;
                    end
                end
                // Multiply keeps the multiplier in lo_acc; divide shifts the dividend out of it.
                PREP: begin
                    hi_acc    <= '0;
                    lo_acc    <= is_div_op ? abs_a : abs_b;
                    operand_q <= is_div_op ? abs_b : abs_a;
                    res_neg   <= a_neg ^ b_neg;
                    rem_neg   <= a_neg;
                    dbz_q     <= is_div_op && (b_q == '0);
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    hi_acc <= step_hi;
                    lo_acc <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
                end
                FIX: begin
                    if (dbz_q) begin
                        hi_q <= a_q;
                        lo_q <= DATA_W'(signed'(DBZ_LO));
                    end else if (is_div_op) begin
                        lo_q <= res_neg ? -lo_acc : lo_acc;
                        hi_q <= rem_neg ? -hi_acc : hi_acc;
                    end else if (res_neg) begin
                        {hi_q, lo_q} <= neg_prod;
                    end else begin
                        {hi_q, lo_q} <= {hi_acc, lo_acc};
                    end
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_div_by_zero = dbz_out_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: hand-computed MIPS mult/div results, latency,
// busy/done timing, MTHI/MTLO handling and mid-operation reset.
module tb_mult_div_seq;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat;
    int          busy_cnt;
    logic [31:0] hi_at_issue;
    int          done_seen;

    mult_div_seq dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_A           (i_A),
        .i_B           (i_B),
        .i_wr_hi       (i_wr_hi),
        .i_wr_lo       (i_wr_lo),
        .i_wr_data     (i_wr_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero),
        .o_hi          (o_hi),
        .o_lo          (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, scrambles the operand inputs after the accepting edge, and waits for o_done.
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat_o, output int busy_o, output logic [31:0] hi_o);
        i_op    = op;
        i_A     = a;
        i_B     = b;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_wr_hi = 1'b0;
        i_wr_lo = 1'b0;
        i_op    = 2'b11;
        i_A     = 32'hDEADBEEF;
        i_B     = 32'h0BADF00D;
        hi_o    = o_hi;
        busy_o  = o_busy ? 1 : 0;
        lat_o   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (o_done) begin
                lat_o = k;
                break;
            end
            if (o_busy) busy_o++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset   = 1'b0;
        i_start   = 1'b0;
        i_op      = 2'b00;
        i_A       = '0;
        i_B       = '0;
        i_wr_hi   = 1'b0;
        i_wr_lo   = 1'b0;
        i_wr_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset_hi",   o_hi, 32'h0);
        check_output("reset_lo",   o_lo, 32'h0);
        check_output("reset_busy", {31'b0, o_busy}, 32'h0);
        check_output("reset_done", {31'b0, o_done}, 32'h0);
        check_output("reset_dbz",  {31'b0, o_div_by_zero}, 32'h0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        $display("[TB] MULTU 0xFFFFFFFF * 0xFFFFFFFF");
        apply_stimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_cnt, hi_at_issue);
        check_output("t1_latency", lat, 34);
        check_output("t1_busy_cycles", busy_cnt, 34);
        check_output("t1_busy_at_done", {31'b0, o_busy}, 32'h0);
        check_output("t1_dbz", {31'b0, o_div_by_zero}, 32'h0);
        check_output("t1_hi", o_hi, 32'hFFFFFFFE);
        check_output("t1_lo", o_lo, 32'h00000001);
        @(posedge i_clk); #1;
        check_output("t1_done_one_cycle", {31'b0, o_done}, 32'h0);
        check_output("t1_hi_hold", o_hi, 32'hFFFFFFFE);

        $display("[TB] MULT -3 * 5, DIV -7 / 2");
        apply_stimulus(2'b00, 32'hFFFFFFFD, 32'h5, lat, busy_cnt, hi_at_issue);
        check_output("t2_mult_latency", lat, 34);
        check_output("t2_mult_hi", o_hi, 32'hFFFFFFFF);
        check_output("t2_mult_lo", o_lo, 32'hFFFFFFF1);
        apply_stimulus(2'b10, 32'hFFFFFFF9, 32'h2, lat, busy_cnt, hi_at_issue);
        check_output("t2_div_latency", lat, 34);
        check_output("t2_div_lo", o_lo, 32'hFFFFFFFD);
        check_output("t2_div_hi", o_hi, 32'hFFFFFFFF);

        $display("[TB] DIVU 0xFFFFFFF9 / 2, DIV -2^31 / -1");
        apply_stimulus(2'b11, 32'hFFFFFFF9, 32'h2, lat, busy_cnt, hi_at_issue);
        check_output("t3_divu_lo", o_lo, 32'h7FFFFFFC);
        check_output("t3_divu_hi", o_hi, 32'h00000001);
        apply_stimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, busy_cnt, hi_at_issue);
        check_output("t3_ovf_lo", o_lo, 32'h80000000);
        check_output("t3_ovf_hi", o_hi, 32'h00000000);

        $display("[TB] DIV by zero");
        apply_stimulus(2'b10, 32'h00001234, 32'h0, lat, busy_cnt, hi_at_issue);
        check_output("t4_latency", lat, 34);
        check_output("t4_dbz_with_done", {31'b0, o_div_by_zero}, 32'h1);
        check_output("t4_hi", o_hi, 32'h00001234);
        check_output("t4_lo", o_lo, 32'hFFFFFFFF);
        @(posedge i_clk); #1;
        check_output("t4_dbz_one_cycle", {31'b0, o_div_by_zero}, 32'h0);

        $display("[TB] ignored start and MTHI while busy");
        i_op = 2'b01; i_A = 32'd6; i_B = 32'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            i_start   = (k == 10);
            i_op      = 2'b01;
            i_A       = (k == 10) ? 32'd2 : 32'h0;
            i_B       = (k == 10) ? 32'd2 : 32'h0;
            i_wr_hi   = (k == 12);
            i_wr_data = 32'h0000AAAA;
            @(posedge i_clk); #1;
            if (k == 12) check_output("t5_mthi_dropped", o_hi, 32'h00001234);
            if (o_done) begin
                lat = k;
                break;
            end
        end
        i_start = 1'b0;
        i_wr_hi = 1'b0;
        check_output("t5_latency", lat, 34);
        check_output("t5_lo", o_lo, 32'd42);
        check_output("t5_hi", o_hi, 32'd0);

        $display("[TB] reset mid-operation");
        i_op = 2'b01; i_A = 32'd6; i_B = 32'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            i_reset = (k != 20);
            @(posedge i_clk); #1;
        end
        check_output("t5_rst_hi", o_hi, 32'h0);
        check_output("t5_rst_lo", o_lo, 32'h0);
        check_output("t5_rst_busy", {31'b0, o_busy}, 32'h0);
        i_reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) done_seen++;
        end
        check_output("t5_no_done_after_rst", done_seen, 0);

        $display("[TB] MTLO/MTHI in IDLE and back-to-back issue");
        i_wr_lo = 1'b1; i_wr_data = 32'h00000055;
        @(posedge i_clk); #1;
        i_wr_lo = 1'b0;
        check_output("t6_mtlo", o_lo, 32'h00000055);
        check_output("t6_mtlo_hi_untouched", o_hi, 32'h0);
        i_wr_hi = 1'b1; i_wr_lo = 1'b1; i_wr_data = 32'h00000077;
        @(posedge i_clk); #1;
        i_wr_hi = 1'b0; i_wr_lo = 1'b0;
        check_output("t6_both_hi", o_hi, 32'h00000077);
        check_output("t6_both_lo", o_lo, 32'h00000077);
        i_wr_hi = 1'b1; i_wr_data = 32'h0000CAFE;
        apply_stimulus(2'b01, 32'd3, 32'd3, lat, busy_cnt, hi_at_issue);
        check_output("t6_mthi_with_start", hi_at_issue, 32'h0000CAFE);
        check_output("t6_first_lo", o_lo, 32'd9);
        check_output("t6_first_hi", o_hi, 32'd0);
        apply_stimulus(2'b11, 32'd100, 32'd7, lat, busy_cnt, hi_at_issue);
        check_output("t6_b2b_busy_cycles", busy_cnt, 34);
        check_output("t6_b2b_latency", lat, 34);
        check_output("t6_b2b_lo", o_lo, 32'd14);
        check_output("t6_b2b_hi", o_hi, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
